// File: rtl/drate_pkg.sv
// ============================================================================
// drate_pkg : shared sample types, 16-bit saturation limits and the
//             reciprocal helper for the drate rate down-converter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package drate_pkg;

  typedef logic signed [15:0] ws16_t;
  typedef logic signed [15:0] rs16_t;

  localparam ws16_t S16_MAX = 16'sh7FFF;
  localparam ws16_t S16_MIN = 16'sh8000;

  // Fractional bits of the reciprocal used to turn a window sum into a mean
  localparam int DRATE_S = 18;

  function automatic int drate_k(input int r, input int s);
    return ((1 << s) + r / 2) / r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drate_scale.sv
// ============================================================================
// drate_scale : stage-2 multiply by reciprocal K and stage-3 round/saturate.
//               Only instantiated when DRATE_AVG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drate_scale
  import drate_pkg::*;
#(
  parameter int AW = 21,
  parameter int K  = 13107,
  parameter int S  = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [AW-1:0] i_win,
  input  logic                 i_vld,
  output ws16_t                o_out,
  output logic                 o_stb
);

  localparam int PW = AW + S + 1;
  localparam logic signed [PW-1:0] c_K    = PW'(K);
  localparam logic signed [PW-1:0] c_HALF = PW'(1 << (S - 1));
  localparam logic signed [PW-1:0] c_MAX  = PW'(S16_MAX);
  localparam logic signed [PW-1:0] c_MIN  = PW'(S16_MIN);

  logic signed [PW-1:0] w_win_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_rnd;
  logic signed [PW-1:0] w_y;
  ws16_t                w_sat;

  logic signed [PW-1:0] r_prod;
  logic                 r_vld;
  ws16_t                r_out;
  logic                 r_stb;

  assign w_win_ext = {{(PW - AW){i_win[AW-1]}}, i_win};
  assign w_prod    = w_win_ext * c_K;
  assign w_rnd     = r_prod + c_HALF;
  assign w_y       = w_rnd >>> S;

  always_comb begin
    if (w_y > c_MAX) begin
      w_sat = S16_MAX;
    end else if (w_y < c_MIN) begin
      w_sat = S16_MIN;
    end else begin
      w_sat = w_y[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      r_vld  <= 1'b0;
      r_out  <= '0;
      r_stb  <= 1'b0;
    end else begin
      r_prod <= w_prod;
      r_vld  <= i_vld;
      r_stb  <= r_vld;
      if (r_vld) begin
        r_out <= w_sat;
      end
    end
  end

  assign o_out = r_out;
  assign o_stb = r_stb;

endmodule

`default_nettype wire

// File: rtl/drate.sv
// ============================================================================
// drate : integer-ratio sample-rate down-converter (R = F_H/F_L).
//         DRATE_AVG_EN defined: boxcar average; undefined: pure decimation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drate
  import drate_pkg::*;
#(
  parameter int F_H = 60,
  parameter int F_L = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  ws16_t in,
  output ws16_t out,
  output logic  out_stb
);

  localparam int R  = F_H / F_L;
  localparam int PW = (R < 2) ? 1 : $clog2(R);
  localparam logic [PW-1:0] c_LAST = PW'(R - 1);

  if ((F_H % F_L != 0) || (R < 2) || (R > 1024)) begin : g_bad_ratio
    $error("drate: F_H/F_L must be an integer ratio in 2..1024");
  end

  logic [PW-1:0] r_phase;
  logic          r_vld1;
  logic          w_last;

  assign w_last = (r_phase == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
      r_vld1  <= 1'b0;
    end else if (w_last) begin
      r_phase <= '0;
      r_vld1  <= 1'b1;
    end else begin
      r_phase <= r_phase + PW'(1);
      r_vld1  <= 1'b0;
    end
  end

`ifdef DRATE_AVG_EN
  localparam int AW = 16 + $clog2(R);
  localparam int K  = drate_k(R, DRATE_S);

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] r_win;
  logic signed [AW-1:0] w_sum;

  assign w_sum = r_acc + {{(AW - 16){in[15]}}, in};

  // The last sample of a window goes straight into win, so acc restarts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_win <= '0;
    end else if (w_last) begin
      r_win <= w_sum;
      r_acc <= '0;
    end else begin
      r_acc <= w_sum;
    end
  end

  drate_scale #(
    .AW (AW),
    .K  (K),
    .S  (DRATE_S)
  ) u_scale (
    .clk   (clk),
    .rst   (rst),
    .i_win (r_win),
    .i_vld (r_vld1),
    .o_out (out),
    .o_stb (out_stb)
  );
`else
  ws16_t r_win;
  ws16_t r_pass;
  logic  r_vld2;
  ws16_t r_out;
  logic  r_stb;

  // Two pass-through stages keep latency identical to the averaging build
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win  <= '0;
      r_pass <= '0;
      r_vld2 <= 1'b0;
      r_out  <= '0;
      r_stb  <= 1'b0;
    end else begin
      if (w_last) begin
        r_win <= in;
      end
      r_pass <= r_win;
      r_vld2 <= r_vld1;
      r_stb  <= r_vld2;
      if (r_vld2) begin
        r_out <= r_pass;
      end
    end
  end

  assign out     = r_out;
  assign out_stb = r_stb;
`endif

endmodule

`default_nettype wire

// File: tb/tb_drate.sv
// ============================================================================
// tb_drate : scoreboard bench for drate; window results are queued by the
//            driver and popped by a monitor whenever out_stb is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drate;
  import drate_pkg::*;

  localparam int     F_H = 60;
  localparam int     F_L = 3;
  localparam int     R   = F_H / F_L;
  localparam int     S   = 18;
  localparam longint K   = ((longint'(1) << S) + R / 2) / R;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  ws16_t in_s = '0;
  ws16_t out_s;
  logic  stb;

  exp_t   q[$];
  int     total = 0;
  int     bad = 0;
  int     edge_n = 0;
  int     wcnt = 0;
  int     wlast = 0;
  longint wsum = 0;

  drate #(.F_H(F_H), .F_L(F_L)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in_s),
    .out     (out_s),
    .out_stb (stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, edge_n);
    end
  endtask

  // Mean of the window: sum * K, round by adding half an LSB, clamp to 16 bits
  function automatic int window_result(input longint sum, input int last);
    longint y;
`ifdef DRATE_AVG_EN
    y = (sum * K + (longint'(1) << (S - 1))) >>> S;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
`else
    y = longint'(last);
`endif
    return int'(y);
  endfunction

  // Called at a negedge; returns at the following negedge
  task automatic drive(input int s);
    exp_t e;
    in_s = 16'(s);
    @(posedge clk);
    edge_n++;
    wsum += longint'(s);
    wlast = s;
    wcnt++;
    if (wcnt == R) begin
      e.val = window_result(wsum, wlast);
      e.due = edge_n + 2;
      q.push_back(e);
      wcnt = 0;
      wsum = 0;
    end
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_out", int'(out_s), 0);
    chk("reset_stb", int'(stb), 0);
    q.delete();
    wcnt = 0;
    wsum = 0;
    edge_n = 0;
    @(negedge clk);
    chk("reset_hold_out", int'(out_s), 0);
    chk("reset_hold_stb", int'(stb), 0);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].due < edge_n) begin
        chk("strobe_missing_due", edge_n, q[0].due);
        void'(q.pop_front());
      end
      if (stb) begin
        if (q.size() == 0) begin
          chk("spurious_strobe_edge", edge_n, -1);
        end else begin
          e = q.pop_front();
          chk("strobe_edge", edge_n, e.due);
          chk("out_value", int'(out_s), e.val);
        end
      end
    end
  end

  initial begin
    int v;
    rst  = 1'b1;
    in_s = '0;
    repeat (2) @(negedge clk);
    chk("por_out", int'(out_s), 0);
    chk("por_stb", int'(stb), 0);
    #1 rst = 1'b0;

    for (int i = 0; i < 3 * R; i++) drive(1000);
    for (int i = 0; i < R; i++) drive(32767);
    for (int i = 0; i < R; i++) drive(-32768);
    for (int i = 0; i < 2 * R; i++) drive(i);

    // One full window of 500 then 7 more samples before an abrupt reset
    for (int i = 0; i < R + 7; i++) drive(500);
    mid_reset();
    for (int i = 0; i < R; i++) drive(200);

    for (int w = 0; w < 40; w++) begin
      for (int i = 0; i < R; i++) begin
        case (w % 8)
          0: v = 32767;
          1: v = -32768;
          default: begin
            case ($urandom_range(0, 7))
              0: v = 32767;
              1: v = -32768;
              default: v = int'($urandom_range(0, 65535)) - 32768;
            endcase
          end
        endcase
        drive(v);
      end
    end

    for (int i = 0; i < 3; i++) drive(0);
    chk("pending_results", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
